sa_sync_nflop_edge: RTL and testbench

SA_SYNC_NFLOP_EDGE -- requirements
Module: sa_sync_nflop_edge

---
 rtl/sa_sync_pkg.sv | 8 +
 rtl/sa_sync_bit.sv | 47 ++++
 rtl/sa_sync_nflop_edge.sv | 37 +++
 tb/tb_sa_sync_nflop_edge.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/sa_sync_pkg.sv
// sa_sync_pkg: shared limits and widths for the synchronizer/deglitch block
package sa_sync_pkg;
   localparam int WIDTH_MAX  = 64;
   localparam int STAGES_MIN = 2;
   localparam int STAGES_MAX = 4;
   localparam int FILTER_MAX = 15;
   localparam int CNT_W      = 4;
endpackage

// File: rtl/sa_sync_bit.sv
// sa_sync_bit: one channel of flop-chain synchronizer, optional deglitch filter and edge pulses
module sa_sync_bit
   import sa_sync_pkg::*;
#(
   parameter int   STAGES     = 2,
   parameter int   FILTER_CNT = 0,
   parameter logic RESET_VAL  = 1'b0
) (
   input  logic clk,
   input  logic clr_,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);
   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain;
   logic s;
   logic qd;
   assign s = chain[STAGES-1];
   // shift the asynchronous input through the synchronizer chain
   always_ff @(posedge clk or negedge clr_)
      if (!clr_) chain <= {STAGES{RESET_VAL}};
      else chain <= {chain[STAGES-2:0], d};
   if (FILTER_CNT == 0) begin : g_bypass
      assign q = s;
   end else begin : g_filt
      localparam logic [CNT_W-1:0] LAST = CNT_W'(FILTER_CNT - 1);
      logic [CNT_W-1:0] cnt;
      logic qf;
      // accept a new level only after it has disagreed with q for FILTER_CNT edges
      always_ff @(posedge clk or negedge clr_)
         if (!clr_) begin
            qf  <= RESET_VAL;
            cnt <= '0;
         end else if (s != qf) begin
            qf  <= (cnt == LAST) ? s : qf;
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
         end else cnt <= '0;
      assign q = qf;
   end
   // remember last q so transitions become one-cycle pulses
   always_ff @(posedge clk or negedge clr_)
      if (!clr_) qd <= RESET_VAL;
      else qd <= q;
   assign rise = q & ~qd;
   assign fall = ~q & qd;
endmodule

// File: rtl/sa_sync_nflop_edge.sv
// sa_sync_nflop_edge: multi-channel synchronizer with deglitch filter and edge detection
module sa_sync_nflop_edge
   import sa_sync_pkg::*;
#(
   parameter int               WIDTH      = 1,
   parameter int               STAGES     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL  = '0,
   parameter int               FILTER_CNT = 0
) (
   input  logic             clk,
   input  logic             clr_,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             any_change
);
   if (WIDTH < 1 || WIDTH > WIDTH_MAX || STAGES < STAGES_MIN || STAGES > STAGES_MAX ||
       FILTER_CNT < 0 || FILTER_CNT > FILTER_MAX) begin : g_bad_param
      $error("sa_sync_nflop_edge: parameter out of range");
   end
   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      sa_sync_bit #(
         .STAGES     (STAGES),
         .FILTER_CNT (FILTER_CNT),
         .RESET_VAL  (RESET_VAL[i])
      ) u_bit (
         .clk  (clk),
         .clr_ (clr_),
         .d    (d[i]),
         .q    (q[i]),
         .rise (rise[i]),
         .fall (fall[i])
      );
   end
   assign any_change = |(rise | fall);
endmodule

// File: tb/tb_sa_sync_nflop_edge.sv
// tb_sa_sync_nflop_edge: randomized check of three configurations against a delay-line/window model
module tb_sa_sync_nflop_edge;
   localparam int         ST [3] = '{3, 2, 2};
   localparam int         FC [3] = '{4, 0, 5};
   localparam logic [7:0] RV [3] = '{8'h0A, 8'hA5, 8'h00};
   logic clk = 1'b0;
   logic clr_ = 1'b0;
   logic [3:0] da = 4'hA;
   logic [7:0] db = 8'hA5;
   logic [1:0] dc = 2'b00;
   logic [3:0] qa, ra, fa;
   logic [7:0] qb, rb, fb;
   logic [1:0] qc, rc, fc;
   logic aca, acb, acc;
   logic [7:0] oq [3], orr [3], ofl [3], oac [3];
   logic [7:0] q_m [3], qd_m [3], s_m [3];
   logic [7:0] dq [3][$];
   logic [7:0] sh [3][$];
   int total = 0;
   int bad = 0;
   always #5 clk = ~clk;
   sa_sync_nflop_edge #(.WIDTH(4), .STAGES(3), .RESET_VAL(4'hA), .FILTER_CNT(4)) u_a (
      .clk(clk), .clr_(clr_), .d(da), .q(qa), .rise(ra), .fall(fa), .any_change(aca));
   sa_sync_nflop_edge #(.WIDTH(8), .STAGES(2), .RESET_VAL(8'hA5), .FILTER_CNT(0)) u_b (
      .clk(clk), .clr_(clr_), .d(db), .q(qb), .rise(rb), .fall(fb), .any_change(acb));
   sa_sync_nflop_edge #(.WIDTH(2), .STAGES(2), .RESET_VAL(2'b00), .FILTER_CNT(5)) u_c (
      .clk(clk), .clr_(clr_), .d(dc), .q(qc), .rise(rc), .fall(fc), .any_change(acc));
   assign oq[0]  = {4'b0, qa};
   assign oq[1]  = qb;
   assign oq[2]  = {6'b0, qc};
   assign orr[0] = {4'b0, ra};
   assign orr[1] = rb;
   assign orr[2] = {6'b0, rc};
   assign ofl[0] = {4'b0, fa};
   assign ofl[1] = fb;
   assign ofl[2] = {6'b0, fc};
   assign oac[0] = {7'b0, aca};
   assign oac[1] = {7'b0, acb};
   assign oac[2] = {7'b0, acc};
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic logic [7:0] dval(input int k);
      return (k == 0) ? {4'b0, da} : (k == 1) ? db : {6'b0, dc};
   endfunction
   task automatic model_reset(input int k);
      q_m[k]  = RV[k];
      qd_m[k] = RV[k];
      s_m[k]  = RV[k];
      dq[k].delete();
      sh[k].delete();
      for (int j = 0; j < ST[k]; j++) dq[k].push_back(RV[k]);
   endtask
   // s is d delayed by STAGES-1 edges; q flips once the last FC pre-edge s samples all disagree with it
   task automatic model_edge(input int k, input logic [7:0] dv);
      logic [7:0] qo;
      logic flip;
      qo = q_m[k];
      sh[k].push_back(s_m[k]);
      if (sh[k].size() > 16) void'(sh[k].pop_front());
      dq[k].push_back(dv);
      void'(dq[k].pop_front());
      s_m[k] = dq[k][0];
      if (FC[k] == 0) q_m[k] = s_m[k];
      else if (sh[k].size() >= FC[k])
         for (int i = 0; i < 8; i++) begin
            flip = 1'b1;
            for (int j = 0; j < FC[k]; j++)
               if (sh[k][sh[k].size() - 1 - j][i] == qo[i]) flip = 1'b0;
            if (flip) q_m[k][i] = ~qo[i];
         end
      qd_m[k] = qo;
   endtask
   always @(posedge clk)
      for (int k = 0; k < 3; k++)
         if (!clr_) model_reset(k);
         else model_edge(k, dval(k));
   task automatic check_all(input string tag);
      logic [7:0] er, ef;
      for (int k = 0; k < 3; k++) begin
         er = q_m[k] & ~qd_m[k];
         ef = ~q_m[k] & qd_m[k];
         chk($sformatf("%s.q%0d", tag, k), oq[k], q_m[k]);
         chk($sformatf("%s.rise%0d", tag, k), orr[k], er);
         chk($sformatf("%s.fall%0d", tag, k), ofl[k], ef);
         chk($sformatf("%s.any%0d", tag, k), oac[k], {7'b0, |(er | ef)});
         chk($sformatf("%s.excl%0d", tag, k), orr[k] & ofl[k], 8'h00);
      end
   endtask
   function automatic logic [7:0] tmask();
      logic [7:0] m;
      for (int i = 0; i < 8; i++) m[i] = ($urandom_range(0, 3) == 0);
      return m;
   endfunction
   initial begin
      for (int k = 0; k < 3; k++) model_reset(k);
      repeat (3) @(negedge clk);
      check_all("rst");
      chk("rst_qb", qb, 8'hA5);
      chk("rst_qa", {4'b0, qa}, 8'h0A);
      clr_ = 1'b1;
      db = 8'h5A;
      dc = 2'b11;
      for (int n = 1; n <= 7; n++) begin
         @(posedge clk);
         @(negedge clk);
         check_all($sformatf("dir%0d", n));
         if (n == 1) chk("rel_any", {5'b0, aca, acb, acc}, 8'h00);
         if (n == 2) begin
            chk("b_q", qb, 8'h5A);
            chk("b_rise", rb, 8'h5A);
            chk("b_fall", fb, 8'hA5);
         end
         if (n == 6) chk("c_hold", {6'b0, qc}, 8'h00);
         if (n == 7) begin
            chk("c_q", {6'b0, qc}, 8'h03);
            chk("c_rise", {6'b0, rc}, 8'h03);
         end
      end
      for (int c = 0; c < 400; c++) begin
         if (c == 200) begin
            clr_ = 1'b0;
            for (int k = 0; k < 3; k++) model_reset(k);
            #1;
            check_all("arst");
            chk("arst_qa", {4'b0, qa}, 8'h0A);
            chk("arst_qc", {6'b0, qc}, 8'h00);
            repeat (2) @(negedge clk);
            check_all("arst_hold");
            clr_ = 1'b1;
         end
         da = da ^ tmask()[3:0];
         db = db ^ tmask();
         dc = dc ^ tmask()[1:0];
         @(posedge clk);
         @(negedge clk);
         check_all("rnd");
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
